rom_boot_loader: RTL and testbench
==================================

Name: rom_boot_loader

Overview:
- Boot-time sequencer for the SoC instruction ROM: replaces simulation-only memory preloading with a loadable path.
- Accepts a byte stream over a valid/ready interface, packs bytes into 32-bit little-endian words and writes them sequentially into the ROM write port.
- Holds the RISC-V core in reset until a complete image with a correct checksum has been written, then releases the core.
- Sits between an external byte source (UART receiver or testbench driver) and the rom / riscv_core instances inside riscv_soc.

Parameters:
ADDR_W, 12, ROM word-address width; legal range 1..16.
TIMEOUT_CYC, 1024, maximum idle cycles allowed between bytes once loading has started; minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  one clock; reset is asynchronous and active-high.
in_valid  input  1  byte source has a byte.
in_data  input  8  byte value.
in_ready  output  1  loader can accept a byte; a transfer occurs on a cycle where in_valid and in_ready are both 1.
rom_we  output  1  ROM write strobe; one cycle per word.
rom_waddr  output  ADDR_W  ROM word address.
rom_wdata  output  32  ROM write data.
core_hold  output  1  1 holds the core in reset; the SoC drives core rst_n = ~core_hold & rst_n_sys.
done  output  1  image loaded and verified; core running.
err  output  1  load failed; sticky until rst.

Behaviour:
- Reset values: in_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0, core_hold=1, done=0, err=0. State is LEN0. All counters and the checksum register are 0.
- in_ready is 1 in LEN0, LEN1, DATA and CSUM. It is registered and rises the first cycle after rst deasserts.
- Stream format:
  - 16-bit little-endian word count N (low byte first).
  - Then 4*N payload bytes.
  - Then 1 checksum byte equal to the XOR of all payload bytes.
- State LEN0: on transfer, latch N[7:0] -> LEN1.
- State LEN1: on transfer, latch N[15:8]. Then:
  - N > 2^ADDR_W -> ERR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- State DATA:
  - Byte counter b (0..3) places each byte at bits [8b+7:8b] of the word.
  - Each byte is XORed into the checksum.
  - On the 4th byte: the following cycle rom_we=1 for exactly one cycle, with rom_waddr = word index w and rom_wdata = the assembled word. Then w increments.
  - After word N-1 is accepted -> CSUM.
  - The write latency of 1 cycle never stalls in_ready.
- State CSUM: on transfer, compare the byte with the checksum register.
  - Match -> RUN.
  - Mismatch -> ERR.
  - Any rom_we pending for the final word completes in the same cycle (it never overlaps a later write).
- State RUN: done=1 and core_hold=0 from the cycle after the checksum transfer. in_ready=0. Further bytes are ignored. Terminal state until rst.
- State ERR: err=1 and core_hold=1; in_ready=0; rom_we=0. Terminal state until rst.
- Timeout:
  - The idle counter is cleared on every transfer.
  - It counts cycles without a transfer in LEN1, DATA and CSUM only; LEN0 waits forever.
  - Counter reaches TIMEOUT_CYC -> ERR. The timeout is checked after the transfer, so a byte arriving on the expiry cycle is accepted and the counter clears.
- Word index wrap: w never exceeds N-1, so there is no wrap. When N = 2^ADDR_W, the last address is all-ones.
- Asserting rst mid-load immediately forces reset values. Partially written ROM contents are left as-is, and the next load overwrites them from address 0.

Decomposition:
- Package boot_pkg holds:
  - state encoding: LEN0, LEN1, DATA, CSUM, RUN, ERR;
  - LEN_BYTES=2;
  - WORD_BYTES=4;
  - a function computing the timeout-counter width (clog2 of TIMEOUT_CYC+1).
- One sub-module, byte_word_packer: owns the byte counter, the shift/placement of bytes into the 32-bit word, and the registered write strobe. It has a clear input that is driven on state entry to DATA.
- The FSM, idle counter, checksum and word index live in rom_boot_loader.

Test Plan:
- Normal load, N=2: stream 02 00 13 00 00 00 93 00 10 00 90 ->
  - rom writes (0,0x00000013) then (1,0x00100093), each rom_we one cycle wide;
  - done=1 and core_hold=0 the cycle after byte 0x90;
  - in_ready=0 afterwards.
- Bad checksum: same stream with a final byte of 0x91 -> err=1, core_hold stays 1, done=0; both ROM writes still occurred.
- Empty image, N=0: stream 00 00 00 -> no rom_we; done=1 after the 3rd byte. Stream 00 00 05 -> err=1.
- Oversize length (ADDR_W=12): stream 01 10 (N=4097) -> err=1 after the 2nd byte, no rom_we. Stream 00 10 (N=4096) must be accepted.
- Timeout (TIMEOUT_CYC=16):
  - Send 02 00 13, then hold in_valid=0 -> err=1 exactly 16 cycles after the last transfer.
  - A repeat run with a byte arriving on cycle 16 continues the load normally.
- Reset mid-load:
  - Assert rst during the DATA state of the N=2 load after 5 payload bytes -> outputs return to reset values immediately.
  - A fresh full load then writes address 0 first and completes with done=1.
- Backpressure: random gaps in in_valid, each shorter than TIMEOUT_CYC, during the normal load -> identical write sequence and done timing relative to the last byte.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the ROM boot loader.
// Holds the loader state encoding, stream framing sizes and the idle-counter width helper.
package boot_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = BYTE_W * LEN_BYTES;
  localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;

  // Width needed to hold an idle count of 0..cyc inclusive.
  function automatic int unsigned tmo_width(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// Issues a one-cycle write strobe with the completed word on the cycle after its last byte.
module byte_word_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] data,
  output logic              word_done_c,
  output logic              we,
  output logic [WORD_W-1:0] word
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);
  localparam int unsigned ACC_W = WORD_W - BYTE_W;

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;

  assign word_done_c = push && (cnt == CNT_W'(WORD_BYTES - 1));

  // Byte placement: lower bytes wait in acc, the top byte completes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      acc  <= '0;
      we   <= 1'b0;
      word <= '0;
    end else begin
      we <= word_done_c;
      if (clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (push) begin
        cnt <= cnt + CNT_W'(1);
        case (cnt)
          CNT_W'(0): acc[7:0]   <= data;
          CNT_W'(1): acc[15:8]  <= data;
          CNT_W'(2): acc[23:16] <= data;
          default:   word       <= {data, acc};
        endcase
      end
    end
  end

endmodule

// File: rtl/rom_boot_loader.sv
// Boot sequencer: receives a length-prefixed, checksummed byte image, writes it into the ROM
// and releases the core from reset only once the whole image has verified.
module rom_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned TW = tmo_width(TIMEOUT_CYC);
  localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_t            state;
  state_t            next_state;
  logic [BYTE_W-1:0] len_lo;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_full_c;
  logic [ADDR_W-1:0] w;
  logic [BYTE_W-1:0] csum;
  logic [TW-1:0]     idle;
  logic              xfer_c;
  logic              push_c;
  logic              counting_c;
  logic              timeout_c;
  logic              oversize_c;
  logic              last_word_c;
  logic              word_done_c;
  logic              pack_clear_c;

  assign xfer_c      = in_valid && in_ready;
  assign push_c      = xfer_c && (state == DATA);
  assign len_full_c  = {in_data, len_lo};
  assign oversize_c  = {1'b0, len_full_c} > MAX_WORDS;
  assign last_word_c = (LEN_W'(w) == (len - LEN_W'(1)));
  assign counting_c  = (state == LEN1) || (state == DATA) || (state == CSUM);
  // A transfer on the expiry cycle wins over the timeout.
  assign timeout_c   = counting_c && !xfer_c && (idle == TW'(TIMEOUT_CYC - 1));

  byte_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (pack_clear_c),
    .push        (push_c),
    .data        (in_data),
    .word_done_c (word_done_c),
    .we          (rom_we),
    .word        (rom_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LEN0;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    pack_clear_c = 1'b0;
    case (state)
      LEN0: begin
        if (xfer_c) next_state = LEN1;
      end
      LEN1: begin
        if (xfer_c) begin
          if (oversize_c) begin
            next_state = ERR;
          end else if (len_full_c == '0) begin
            next_state = CSUM;
          end else begin
            next_state   = DATA;
            pack_clear_c = 1'b1;
          end
        end
      end
      DATA: begin
        if (word_done_c && last_word_c) next_state = CSUM;
      end
      CSUM: begin
        if (xfer_c) next_state = (in_data == csum) ? RUN : ERR;
      end
      RUN:     next_state = RUN;
      ERR:     next_state = ERR;
      default: next_state = ERR;
    endcase
    if (timeout_c) next_state = ERR;
  end

  // Length, word index, running checksum and inter-byte idle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo    <= '0;
      len       <= '0;
      w         <= '0;
      csum      <= '0;
      idle      <= '0;
      rom_waddr <= '0;
    end else begin
      if (xfer_c && (state == LEN0)) len_lo <= in_data;
      if (xfer_c && (state == LEN1)) begin
        len <= len_full_c;
        w   <= '0;
      end
      if (push_c) csum <= csum ^ in_data;
      if (word_done_c) begin
        rom_waddr <= w;
        if (!last_word_c) w <= w + ADDR_W'(1);
      end
      idle <= (xfer_c || !counting_c) ? '0 : idle + TW'(1);
    end
  end

  // Handshake and status outputs follow the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_ready  <= (next_state == LEN0) || (next_state == LEN1) ||
                   (next_state == DATA) || (next_state == CSUM);
      core_hold <= (next_state != RUN);
      done      <= (next_state == RUN);
      err       <= (next_state == ERR);
    end
  end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Randomized self-checking bench for rom_boot_loader against a stream-level reference model.
module tb_rom_boot_loader;

  localparam int unsigned ADDR_W      = 12;
  localparam int unsigned TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_waddr;
  logic [31:0]       rom_wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [7:0]        stream[$];
  int                gaps[$];
  int                exp_a[$];
  logic [31:0]       exp_d[$];
  logic [ADDR_W-1:0] got_a[$];
  logic [31:0]       got_d[$];
  int                dbl = 0;
  logic              we_d = 1'b0;

  rom_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .core_hold (core_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Capture every ROM write; back-to-back strobes would mean a stretched or duplicated write.
  always @(negedge clk) begin
    if (rom_we) begin
      got_a.push_back(rom_waddr);
      got_d.push_back(rom_wdata);
      if (we_d) dbl++;
    end
    we_d = rom_we;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_rom_we", 32'(rom_we), 32'd0);
    check_eq("rst_waddr", 32'(rom_waddr), 32'd0);
    check_eq("rst_wdata", rom_wdata, 32'd0);
    check_eq("rst_core_hold", 32'(core_hold), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    got_a.delete();
    got_d.delete();
    dbl = 0;
    @(posedge clk); #1;
    check_eq("ready_after_rst", 32'(in_ready), 32'd1);
  endtask

  // Drive stream[0..cnt-1], inserting gaps[i] idle cycles before byte i.
  task automatic send(input int cnt);
    logic rdy;
    int   budget;
    for (int i = 0; i < cnt; i++) begin
      if (gaps.size() > i && gaps[i] > 0) begin
        in_valid = 1'b0;
        repeat (gaps[i]) @(posedge clk);
        #1;
      end
      if (i == cnt - 1) begin
        check_eq("pre_last_done", 32'(done), 32'd0);
        check_eq("pre_last_err", 32'(err), 32'd0);
      end
      in_valid = 1'b1;
      in_data  = stream[i];
      budget   = 0;
      do begin
        rdy = in_ready;
        @(posedge clk); #1;
        budget++;
      end while (!rdy && budget < 20);
      if (!rdy) begin
        check_eq("xfer_bound", 32'(rdy), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Reference model works on the whole stream: decode length, slice words, fold checksum.
  task automatic do_load(input string tag);
    int         n;
    int         cons;
    bit         ok;
    int         nwr;
    logic [7:0] x;
    exp_a.delete();
    exp_d.delete();
    x = 8'h00;
    n = int'(stream[0]) + 256 * int'(stream[1]);
    if (n > (1 << ADDR_W)) begin
      cons = 2;
      ok   = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_a.push_back(i);
        exp_d.push_back({stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]});
        for (int k = 0; k < 4; k++) x ^= stream[2+4*i+k];
      end
      cons = 3 + 4 * n;
      ok   = (stream[2+4*n] == x);
    end
    send(cons);
    check_eq({tag, "_done"}, 32'(done), 32'(ok));
    check_eq({tag, "_err"}, 32'(err), 32'(!ok));
    check_eq({tag, "_hold"}, 32'(core_hold), 32'(!ok));
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    nwr = got_a.size();
    check_eq({tag, "_nwr"}, 32'(nwr), 32'(exp_a.size()));
    for (int i = 0; i < nwr && i < exp_a.size(); i++) begin
      check_eq({tag, "_waddr"}, 32'(got_a[i]), 32'(exp_a[i]));
      check_eq({tag, "_wdata"}, got_d[i], exp_d[i]);
    end
    check_eq({tag, "_we_width"}, 32'(dbl), 32'd0);
    check_eq({tag, "_done_stays"}, 32'(done), 32'(ok));
  endtask

  task automatic load_normal(input logic [7:0] last);
    logic [7:0] s[11];
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, last};
    stream.delete();
    gaps.delete();
    foreach (s[i]) stream.push_back(s[i]);
  endtask

  initial begin
    int         n;
    logic [7:0] x;
    logic [7:0] b;
    repeat (2) @(posedge clk);
    #1;

    apply_reset();
    load_normal(8'h90);
    do_load("normal");

    apply_reset();
    load_normal(8'h91);
    do_load("badcsum");

    apply_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    gaps.delete();
    do_load("empty_ok");

    apply_reset();
    stream = '{8'h00, 8'h00, 8'h05};
    do_load("empty_bad");

    apply_reset();
    stream = '{8'h01, 8'h10};
    do_load("oversize");

    // Timeout: error lands exactly TIMEOUT_CYC cycles after the last transfer.
    apply_reset();
    load_normal(8'h90);
    send(3);
    repeat (TIMEOUT_CYC - 1) @(posedge clk);
    #1;
    check_eq("tmo_early", 32'(err), 32'd0);
    @(posedge clk); #1;
    check_eq("tmo_err", 32'(err), 32'd1);
    check_eq("tmo_hold", 32'(core_hold), 32'd1);
    check_eq("tmo_ready", 32'(in_ready), 32'd0);

    apply_reset();
    load_normal(8'h90);
    gaps = '{0, 0, 0, TIMEOUT_CYC - 1};
    do_load("tmo_edge");

    // Reset in the middle of the payload, then a clean reload.
    apply_reset();
    load_normal(8'h90);
    send(7);
    apply_reset();
    load_normal(8'h90);
    do_load("reload");

    apply_reset();
    load_normal(8'h90);
    for (int i = 0; i < stream.size(); i++) gaps.push_back($urandom_range(0, TIMEOUT_CYC - 2));
    do_load("backpressure");

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 6);
      x = 8'h00;
      stream.delete();
      gaps.delete();
      stream.push_back(8'(n));
      stream.push_back(8'h00);
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom);
        x ^= b;
        stream.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
      stream.push_back(x);
      for (int k = 0; k < stream.size(); k++)
        gaps.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0);
      apply_reset();
      do_load("rand");
    end

    // Largest legal image: last write must hit the all-ones address.
    apply_reset();
    stream.delete();
    gaps.delete();
    x = 8'h00;
    stream.push_back(8'h00);
    stream.push_back(8'h10);
    for (int k = 0; k < 4 * (1 << ADDR_W); k++) begin
      b = 8'($urandom);
      x ^= b;
      stream.push_back(b);
    end
    stream.push_back(x);
    do_load("full");
    if (got_a.size() > 0) check_eq("full_last_addr", 32'(got_a[got_a.size()-1]), 32'((1 << ADDR_W) - 1));
    else check_eq("full_any_write", 32'(got_a.size()), 32'(1 << ADDR_W));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
